// File: rtl/apb_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile_if
//   APB bus bundle between a master and the apb_slave_regfile completer.
//
//   Signals:
//     paddr       master -> slave  byte address
//     psel        master -> slave  slave select
//     penable     master -> slave  access phase indicator
//     pwrite      master -> slave  1 = write, 0 = read
//     pwdata      master -> slave  write data
//     wait_cycles master -> slave  wait states for the next transfer
//     pstrb       master -> slave  byte-lane write strobes (APB_SLAVE_WSTRB_EN only)
//     prdata      slave -> master  read data
//     pready      slave -> master  transfer completion
//     pslverr     slave -> master  error response
//
//   Optional feature macro: APB_SLAVE_WSTRB_EN (adds pstrb).
// ---------------------------------------------------------------------------
interface apb_slave_regfile_if #(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0]   paddr;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [APB_DATA_WIDTH-1:0]   pwdata;
    logic [3:0]                  wait_cycles;
`ifdef APB_SLAVE_WSTRB_EN
    logic [APB_DATA_WIDTH/8-1:0] pstrb;
`endif
    logic [APB_DATA_WIDTH-1:0]   prdata;
    logic                        pready;
    logic                        pslverr;

`ifdef APB_SLAVE_WSTRB_EN
    modport master (
        output paddr, psel, penable, pwrite, pwdata, wait_cycles, pstrb,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, wait_cycles, pstrb,
        output prdata, pready, pslverr
    );
`else
    modport master (
        output paddr, psel, penable, pwrite, pwdata, wait_cycles,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, wait_cycles,
        output prdata, pready, pslverr
    );
`endif
endinterface

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//   APB completer terminating transfers into a small word-addressed register
//   file. Each transfer carries its own wait-state count (sampled in the
//   setup phase). Addresses below BASE_ADDR, misaligned addresses and
//   addresses past the last register complete with pslverr=1; erroring
//   writes leave the registers untouched and erroring reads return 0.
//
//   Ports:
//     clk   input   clock, all logic on the rising edge
//     rstn  input   synchronous active-low reset
//     bus   slave modport of apb_slave_regfile_if
//             (paddr, psel, penable, pwrite, pwdata, wait_cycles[, pstrb]
//              in; prdata, pready, pslverr out, all outputs from flops)
//
//   Parameters:
//     APB_ADDR_WIDTH  width of paddr
//     APB_DATA_WIDTH  data width, 8, 16 or 32
//     REG_NUM         number of registers, 1..256
//     BASE_ADDR       byte address of register 0, word aligned
//
//   Optional feature macro: APB_SLAVE_WSTRB_EN
//     defined   : writes update only byte lanes whose pstrb bit is set
//     undefined : every write updates all byte lanes
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned REG_NUM        = 16,
    parameter int unsigned BASE_ADDR      = 0
) (
    input logic                clk,
    input logic                rstn,
    apb_slave_regfile_if.slave bus
);

    localparam int unsigned NBYTES  = APB_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SH = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int unsigned IDX_W   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    // Wide enough to hold both any word index and REG_NUM (<= 256).
    localparam int unsigned CMP_W   = APB_ADDR_WIDTH + 9;

    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'(NBYTES - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] BASE       = APB_ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t state_q, state_d;

    // Transfer context latched in the setup phase.
    logic [3:0]                cnt_q;
    logic                      wr_q;
    logic                      err_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0]         strb_q;

    // Register file and registered outputs.
    logic [APB_DATA_WIDTH-1:0] rf_q [REG_NUM];
    logic [APB_DATA_WIDTH-1:0] prdata_q;
    logic                      pready_q;
    logic                      pslverr_q;

    // Setup-phase address decode.
    logic                      setup;
    logic [APB_ADDR_WIDTH:0]   offset_ext;
    logic                      below_base;
    logic                      misaligned;
    logic [APB_ADDR_WIDTH-1:0] word_idx;
    logic                      out_of_range;
    logic                      addr_err;
    logic [IDX_W-1:0]          idx_d;
    logic [APB_DATA_WIDTH-1:0] rd_word;
    logic [NBYTES-1:0]         strb_d;
    logic                      err_next;
    logic                      commit;

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

    assign setup = (state_q == ST_IDLE) && bus.psel && !bus.penable;

    // The extra MSB of the subtraction is the borrow, so addresses below the
    // base are flagged instead of wrapping around into a valid index.
    assign offset_ext   = {1'b0, bus.paddr} - {1'b0, BASE};
    assign below_base   = offset_ext[APB_ADDR_WIDTH];
    assign misaligned   = |(bus.paddr & ALIGN_MASK);
    assign word_idx     = offset_ext[APB_ADDR_WIDTH-1:0] >> BYTE_SH;
    assign out_of_range = CMP_W'(word_idx) >= CMP_W'(REG_NUM);
    assign addr_err     = below_base || misaligned || out_of_range;
    assign idx_d        = IDX_W'(word_idx);

    // Only dereference the array when the index is known to be in range.
    always_comb begin
        rd_word = '0;
        if (!addr_err) begin
            rd_word = rf_q[idx_d];
        end
    end

`ifdef APB_SLAVE_WSTRB_EN
    assign strb_d = bus.pstrb;
`else
    assign strb_d = '1;
`endif

    // Error flag that will be valid in the cycle after this edge. A zero-wait
    // transfer reaches READY on the setup edge itself, before err_q is loaded.
    assign err_next = setup ? addr_err : err_q;

    assign commit = (state_q == ST_READY) && bus.psel && bus.penable
                    && wr_q && !err_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d = (bus.wait_cycles == 4'd0) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer context, wait counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            if (setup) begin
                cnt_q   <= bus.wait_cycles;
                wr_q    <= bus.pwrite;
                err_q   <= addr_err;
                idx_q   <= idx_d;
                wdata_q <= bus.pwdata;
                strb_q  <= strb_d;
                if (!bus.pwrite) begin
                    prdata_q <= rd_word;
                end
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end

            pready_q  <= (state_d == ST_READY);
            pslverr_q <= (state_d == ST_READY) && err_next;
        end
    end

    // ------------------------------------------------------------------
    // Register file: cleared on reset, written at the end of READY
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
        end else if (commit) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (strb_q[b]) begin
                    rf_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regfile
//   Directed self-checking bench for apb_slave_regfile (32-bit data,
//   16 registers, base address 0). Set APB_SLAVE_WSTRB_EN to also exercise
//   byte-lane strobes.
// ---------------------------------------------------------------------------
module tb_apb_slave_regfile;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rstn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_slave_regfile_if #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW)
    ) bus ();

    apb_slave_regfile #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .REG_NUM(16),
        .BASE_ADDR(0)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives setup then access, returns inside the READY cycle with the bus
    // still in access phase, so the next call's first edge is the commit edge.
    task automatic apb_xfer(input logic [15:0] addr, input logic wr,
                            input logic [31:0] wdata, input logic [3:0] waits,
                            output int lat);
        @(posedge clk); #1;
        bus.paddr       = addr;
        bus.pwrite      = wr;
        bus.pwdata      = wdata;
        bus.wait_cycles = waits;
        bus.psel        = 1'b1;
        bus.penable     = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        lat = 1;
        while (!bus.pready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr,
                            input logic [31:0] data, input logic [3:0] waits,
                            input logic exp_err);
        int lat;
        apb_xfer(addr, 1'b1, data, waits, lat);
        check({tag, "_lat"}, 32'(lat), 32'(waits) + 32'd1);
        check({tag, "_err"}, 32'(bus.pslverr), 32'(exp_err));
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr,
                           input logic [3:0] waits, input logic [31:0] exp_data,
                           input logic exp_err);
        int lat;
        apb_xfer(addr, 1'b0, 32'h0, waits, lat);
        check({tag, "_lat"}, 32'(lat), 32'(waits) + 32'd1);
        check({tag, "_err"}, 32'(bus.pslverr), 32'(exp_err));
        check({tag, "_data"}, bus.prdata, exp_data);
    endtask

    task automatic go_idle(input string tag);
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        check({tag, "_pready_low"}, 32'(bus.pready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        rstn            = 1'b0;
        bus.paddr       = '0;
        bus.psel        = 1'b0;
        bus.penable     = 1'b0;
        bus.pwrite      = 1'b0;
        bus.pwdata      = '0;
        bus.wait_cycles = '0;
`ifdef APB_SLAVE_WSTRB_EN
        bus.pstrb       = '1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  32'(bus.pready),  32'd0);
        check("rst_pslverr", 32'(bus.pslverr), 32'd0);
        check("rst_prdata",  bus.prdata,       32'h0);
        rstn = 1'b1;

        // Wait-state read straight after reset: pready 4 cycles after setup.
        do_read("rd8_w3", 16'h0008, 4'd3, 32'h0, 1'b0);
        go_idle("rd8_w3");

        // Zero-wait write then read of the same word.
        do_write("wr4", 16'h0004, 32'hDEADBEEF, 4'd0, 1'b0);
        do_read("rd4", 16'h0004, 4'd0, 32'hDEADBEEF, 1'b0);
        go_idle("rd4");

        // Errors: out of range (would alias reg 0 if truncated) and misaligned.
        do_write("wr0", 16'h0000, 32'hCAFEF00D, 4'd1, 1'b0);
        go_idle("wr0");
        do_write("wr40_err", 16'h0040, 32'h0BADBAD0, 4'd0, 1'b1);
        go_idle("wr40_err");
        do_write("wr2_err", 16'h0002, 32'h0BADBAD1, 4'd2, 1'b1);
        go_idle("wr2_err");
        do_read("rd40_err", 16'h0040, 4'd0, 32'h0, 1'b1);
        do_read("rdfffc_err", 16'hFFFC, 4'd1, 32'h0, 1'b1);
        do_read("rd0_kept", 16'h0000, 4'd0, 32'hCAFEF00D, 1'b0);
        go_idle("rd0_kept");

        // prdata holds its last read value across a write.
        do_write("wr8", 16'h0008, 32'h00000012, 4'd2, 1'b0);
        check("prdata_hold", bus.prdata, 32'hCAFEF00D);
        go_idle("wr8");

        // Back-to-back write then read, no idle cycle between.
        do_write("b2b_wr", 16'h0000, 32'h00000011, 4'd0, 1'b0);
        do_read("b2b_rd", 16'h0000, 4'd0, 32'h00000011, 1'b0);
        go_idle("b2b_rd");

        // Abort during WAIT: no completion and no write.
        @(posedge clk); #1;
        bus.paddr = 16'h0010; bus.pwrite = 1'b1; bus.pwdata = 32'h000000AA;
        bus.wait_cycles = 4'd3; bus.psel = 1'b1; bus.penable = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1;
        check("abort_wait_pready", 32'(bus.pready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_wait_late", 32'(bus.pready), 32'd0);
        do_read("abort_wait_rd", 16'h0010, 4'd0, 32'h0, 1'b0);
        go_idle("abort_wait_rd");

        // Abort during READY: psel dropped before the commit edge.
        do_write("abort_rdy_wr", 16'h0014, 32'h00000077, 4'd0, 1'b0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        do_read("abort_rdy_rd", 16'h0014, 4'd0, 32'h0, 1'b0);
        go_idle("abort_rdy_rd");

        // penable without a preceding setup is ignored.
        @(posedge clk); #1;
        bus.paddr = 16'h0000; bus.pwrite = 1'b0; bus.wait_cycles = 4'd0;
        bus.psel = 1'b1; bus.penable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("penable_only_pready", 32'(bus.pready), 32'd0);
        go_idle("penable_only");

        // Reset in the WAIT of a write: transfer dropped, registers cleared.
        do_read("pre_rst_rd", 16'h0000, 4'd0, 32'h00000011, 1'b0);
        go_idle("pre_rst_rd");
        @(posedge clk); #1;
        bus.paddr = 16'h000C; bus.pwrite = 1'b1; bus.pwdata = 32'h00000055;
        bus.wait_cycles = 4'd3; bus.psel = 1'b1; bus.penable = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_pready",  32'(bus.pready), 32'd0);
        check("midrst_prdata",  bus.prdata,      32'h0);
        rstn = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        do_read("midrst_rdc", 16'h000C, 4'd0, 32'h0, 1'b0);
        do_read("midrst_rd0", 16'h0000, 4'd0, 32'h0, 1'b0);
        go_idle("midrst_rd0");

`ifdef APB_SLAVE_WSTRB_EN
        bus.pstrb = 4'b1111;
        do_write("strb_full", 16'h0018, 32'hFFFFFFFF, 4'd0, 1'b0);
        bus.pstrb = 4'b0101;
        do_write("strb_0101", 16'h0018, 32'h12345678, 4'd1, 1'b0);
        bus.pstrb = 4'b0000;
        do_write("strb_none", 16'h0018, 32'h00000000, 4'd0, 1'b0);
        bus.pstrb = 4'b0000;
        do_read("strb_rd", 16'h0018, 4'd0, 32'hFF34FF78, 1'b0);
        go_idle("strb_rd");
        bus.pstrb = 4'b1111;
`endif

        lat = 0;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB completer (slave) that sits on the opposite side of the testbench-driven APB master interface. It terminates APB transfers into a small word-addressed register file. Wait-state count is programmable per transfer, and out-of-range or misaligned addresses return an error response. It serves as the DUT-side responder for APB master verification and as a reusable peripheral register block.

Parameters:
APB_ADDR_WIDTH, 16, width of paddr.
APB_DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32.
REG_NUM, 16, number of data-width registers; range 1..256.
BASE_ADDR, 0, byte address of register 0; must be word-aligned.

Ports:
clk  input  1  clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
paddr  input  APB_ADDR_WIDTH  byte address.
psel  input  1  slave select.
penable  input  1  access phase indicator.
pwrite  input  1  1 = write, 0 = read.
pwdata  input  APB_DATA_WIDTH  write data.
wait_cycles  input  4  wait states for the next transfer; sampled in setup phase.
prdata  output  APB_DATA_WIDTH  read data; valid when pready=1 on a read.
pready  output  1  transfer completion.
pslverr  output  1  error response; valid only with pready=1.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state to IDLE; pready=0, pslverr=0, prdata=0; all registers cleared to 0.
  - A transfer in flight is dropped and any pending write is discarded.
- Outputs are driven directly from flops; there is no combinational path from inputs to outputs.
- Setup detection: psel=1 & penable=0 sampled while in IDLE.
  - On that edge, latch paddr, pwrite, pwdata and wait_cycles into cnt.
  - Compute err = (paddr < BASE_ADDR) | (paddr[1:0] != 0 when DATA=32; paddr[0] != 0 when DATA=16) | (index >= REG_NUM).
  - index = (paddr - BASE_ADDR) / (APB_DATA_WIDTH/8).
  - For reads: prdata <= err ? 0 : reg[index].
- FSM:
  - IDLE -> READY if wait_cycles=0; IDLE -> WAIT otherwise.
  - WAIT: cnt decrements each cycle; when cnt==1 -> READY.
  - READY -> IDLE unconditionally.
- pready=1 exactly while state=READY; pslverr = latched err during READY, 0 elsewhere.
- Latency: setup at cycle T; pready high in cycle T+1+wait_cycles. Zero-wait gives the standard 2-cycle APB transfer.
- Write commit: on the clk edge ending the READY cycle, only if err=0 and psel=1 & penable=1. An erroring write leaves the registers unchanged.
- Back-to-back transfers: the next setup phase arrives in the cycle after READY, while state=IDLE, and is accepted normally.
- Read-after-write to the same address returns the new value.
- Abort: psel=0 sampled in WAIT or READY -> IDLE, pready=0 next cycle, no write.
- penable=1 sampled in IDLE without a preceding setup is ignored and the FSM stays IDLE.
- Addresses beyond BASE_ADDR+REG_NUM*bytes, including wrap-around of the subtraction, are errors, not aliases.
- prdata holds its last value when no read is active.

Optional Feature:
APB_SLAVE_WSTRB_EN:
- When defined: adds input pstrb [APB_DATA_WIDTH/8-1:0], latched at setup.
  - Writes update only byte lanes with pstrb[i]=1.
  - pstrb=0 on a write completes with no change and no error.
  - pstrb is ignored on reads.
- When undefined: no pstrb port, and every write updates all byte lanes.

Test Plan:
- Zero-wait write 0xDEADBEEF to 0x0004, then read 0x0004:
  - pready high one cycle after each setup; pslverr=0; prdata=0xDEADBEEF.
- wait_cycles=3 read of 0x0008 after reset: pready rises exactly 4 cycles after setup; prdata=0; pslverr=0.
- Write to 0x0040 (REG_NUM=16) and to misaligned 0x0002:
  - pready with pslverr=1 for both.
  - A following read of 0x0000 shows the register unchanged.
- Back-to-back: write 0x11 to 0x0 immediately followed by a read of 0x0, with no idle cycle between transfers: the read returns 0x11.
- Reset mid-transfer: assert rstn=0 during the WAIT of a write of 0x55 to 0x000C:
  - pready=0 next cycle.
  - After reset, a read of 0x000C returns 0.
- With APB_SLAVE_WSTRB_EN:
  - Write 0xFFFFFFFF, then write 0x12345678 with pstrb=4'b0101.
  - A read returns 0xFF34FF78.
